timing_sequencer: RTL
=====================

// Module: timing_sequencer
// PURPOSE
//  Sequence counter, timing decoder and control-flag sequencer for the basic computer.
//  Generates one-hot timing signals T0..T15 that step the datapath through each instruction.
//  Owns the start/stop flag S and the interrupt-cycle flag R.
//  Sits between the control decoder (sc_clr, hlt requests) and the I/O flag logic (ien, fgi, fgo).
// PARAMETERS
//  SC_WIDTH    4   sequence counter width; timing vector width is 2**SC_WIDTH
//  S_AT_RESET  0   reset value of s_flag (1 = run immediately out of reset)
// PORTS
//  clk       in   1           system clock; all state updates on rising edge
//  reset     in   1           asynchronous, active-low reset
//  start     in   1           set S (begin running); level, sampled each edge
//  hlt       in   1           clear S (HLT instruction executed)
//  sc_clr    in   1           clear SC at next edge (end of instruction)
//  ien       in   1           interrupt enable flag from the flag block
//  fgi       in   1           input flag
//  fgo       in   1           output flag
//  t_out     out  2**SC_WIDTH one-hot timing signals; t_out[k] = Tk
//  sc_val    out  SC_WIDTH    current sequence count
//  s_flag    out  1           run flag S
//  r_flag    out  1           interrupt-cycle flag R
//  ien_clr   out  1           one-cycle pulse: clear IEN (asserted at R.T2)
//  tseq_err  out  1           sticky SC overflow error (watchdog builds only, else 0)
// BEHAVIOUR
//  Reset (reset=0, async): sc_val=0, s_flag=S_AT_RESET, r_flag=0, tseq_err=0.
//   t_out = (s_flag ? 1 : 0) and ien_clr = 0 while reset is held.
//  States: HALTED (S=0), FETCH (S=1, R=0), INTR (S=1, R=1).
//  HALTED: sc_val held at 0; t_out all zero; R frozen.
//   start=1 & hlt=0 -> FETCH next edge; T0 asserted in the first cycle after S sets.
//  FETCH/INTR, each edge: sc_clr=1 -> SC=0; else SC = SC+1.
//  t_out is combinational from sc_val and s_flag: exactly one bit high when S=1.
//  SC wrap, non-watchdog build: SC at 2**SC_WIDTH-1 with no sc_clr wraps to 0 (T15 -> T0).
//  Start/stop priority:
//   hlt=1 (any state) -> S=0 and SC=0 at next edge; hlt wins over start and sc_clr.
//   start while S=1 -> ignored.
//  R set: at an edge with S=1, R=0, T0|T1|T2 inactive, ien=1, (fgi|fgo)=1 -> R=1 next cycle.
//   The SC update on that edge proceeds normally.
//  INTR: at T2 with R=1 -> R=0, SC=0 (sc_clr implied), ien_clr=1 during the T2 cycle.
//   Combinational: ien_clr = r_flag & t_out[2].
//  Simultaneous events:
//   sc_clr asserted at R.T2 -> single clear, no extra effect.
//   R-set condition true at R.T2 -> R clears anyway (R=1 excludes setting).
//  hlt during INTR -> S=0, SC=0, R retained; the cycle resumes from T0 on restart.
//  Reset mid-operation -> immediate return to reset values; no partial pulse on ien_clr.
// CONFIGURATION
//  TSEQ_WDOG_EN defined: SC reaching 2**SC_WIDTH-1 without sc_clr on that edge
//   -> tseq_err=1 (sticky until reset), S=0, SC=0 (forced halt).
//  TSEQ_WDOG_EN undefined: SC wraps silently; tseq_err tied to 0; no watchdog logic present.
// TESTING
//  1 Reset (S_AT_RESET=0), start pulse 1 cycle
//    -> t_out steps 0x0001,0x0002,0x0004,... one bit per clk.
//  2 Running, sc_clr at T3 -> next cycle t_out=0x0001, sc_val=0;
//    hlt at T1 -> S=0, t_out=0x0000 next cycle.
//  3 ien=1, fgo=1 raised at T4, sc_clr at T5
//    -> r_flag=1 from T5; next T0..T2 in INTR; ien_clr high only in T2; then R=0, T0.
//  4 start & hlt together while HALTED -> stays HALTED;
//    fgi=1 with ien=1 during T0..T2 only -> R stays 0.
//  5 No sc_clr for 16 cycles: default build -> T15 then T0, tseq_err=0;
//    with TSEQ_WDOG_EN -> tseq_err=1, s_flag=0.
//  6 reset asserted mid-INTR at T1 -> r_flag=0, sc_val=0, ien_clr=0 immediately, without a clk edge.

Source files
------------

// File: rtl/timing_sequencer.sv
// Sequence counter, one-hot timing decoder and S/R flag sequencer for the basic computer.
// Build option: define TSEQ_WDOG_EN to enable the sticky SC-overflow watchdog (tseq_err).
module timing_sequencer #(
  parameter int SC_WIDTH   = 4,
  parameter bit S_AT_RESET = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   hlt,
  input  logic                   sc_clr,
  input  logic                   ien,
  input  logic                   fgi,
  input  logic                   fgo,
  output logic [2**SC_WIDTH-1:0] t_out,
  output logic [SC_WIDTH-1:0]    sc_val,
  output logic                   s_flag,
  output logic                   r_flag,
  output logic                   ien_clr,
  output logic                   tseq_err
);

  typedef enum logic [1:0] {HALTED, FETCH, INTR} mode_t;

  mode_t               mode;
  logic [SC_WIDTH-1:0] sc_q, sc_d;
  logic                s_q, s_d;
  logic                r_q, r_d;
  logic                r_set;
  logic                at_t2;

  // Interrupt request is only honoured outside T0..T2 so a fetch in flight is never split.
  assign at_t2 = (int'(sc_q) == 2);
  assign r_set = ien & (fgi | fgo) & (int'(sc_q) > 2);

`ifdef TSEQ_WDOG_EN
  localparam logic [SC_WIDTH-1:0] SC_MAX = '1;
  logic err_q, err_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sc_q  <= '0;
      s_q   <= S_AT_RESET;
      r_q   <= 1'b0;
`ifdef TSEQ_WDOG_EN
      err_q <= 1'b0;
`endif
    end else begin
      sc_q  <= sc_d;
      s_q   <= s_d;
      r_q   <= r_d;
`ifdef TSEQ_WDOG_EN
      err_q <= err_d;
`endif
    end
  end

  always_comb begin
    sc_d  = sc_q;
    s_d   = s_q;
    r_d   = r_q;
    mode  = !s_q ? HALTED : (r_q ? INTR : FETCH);
`ifdef TSEQ_WDOG_EN
    err_d = err_q;
`endif
    case (mode)
      HALTED: begin
        sc_d = '0;
        if (start && !hlt) s_d = 1'b1;
      end
      FETCH: begin
        sc_d = sc_clr ? '0 : sc_q + 1'b1;
        if (r_set) r_d = 1'b1;
      end
      INTR: begin
        if (at_t2) begin
          r_d  = 1'b0;
          sc_d = '0;
        end else begin
          sc_d = sc_clr ? '0 : sc_q + 1'b1;
        end
      end
      default: sc_d = '0;
    endcase
`ifdef TSEQ_WDOG_EN
    if (mode != HALTED && sc_q == SC_MAX && !sc_clr) begin
      err_d = 1'b1;
      s_d   = 1'b0;
      sc_d  = '0;
    end
`endif
    // HLT overrides everything else but leaves R so an interrupt cycle resumes on restart.
    if (hlt) begin
      s_d  = 1'b0;
      sc_d = '0;
      r_d  = r_q;
    end
  end

  always_comb begin
    t_out = '0;
    if (s_q) t_out[sc_q] = 1'b1;
  end

  assign sc_val  = sc_q;
  assign s_flag  = s_q;
  assign r_flag  = r_q;
  assign ien_clr = r_q & t_out[2];
`ifdef TSEQ_WDOG_EN
  assign tseq_err = err_q;
`else
  assign tseq_err = 1'b0;
`endif

endmodule
